// File: rtl/coord_pkg.sv
// Shared definitions for the raster coordinate generator: FSM state encoding
// and the counter-width helper used to size the coordinate buses.
package coord_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of bits needed to encode 0..n-1; never less than one bit, so an
    // un-overridden (negative) size still yields a legal width.
    function automatic int log2_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULUS up-counter with a synchronous clear. The wrap output flags the
// increment that takes the count from MODULUS-1 back to zero, so two of these
// chain directly into a two-dimensional counter.
module mod_counter #(
    parameter int MODULUS = 2,
    parameter int BITW    = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [BITW-1:0] count,
    output logic            wrap
);

    localparam logic [BITW-1:0] LAST = BITW'(MODULUS - 1);

    // A clear wins over an increment, so a clear never reports a wrap.
    assign wrap = inc && !clr && (count == LAST);

    // Count register: clear to zero, otherwise advance and wrap at MODULUS-1.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples the
        // pre-edge values; blocking here would make results depend on block order.
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/raster_coord_gen.sv
// Raster coordinate generator: tags each valid pixel with its (line, column)
// position, frame-aligned by in_fsync, with one cycle of registered latency.
// Optional strict sync checking is enabled by defining RASTER_COORD_SYNC_CHECK_EN;
// without it out_sync_err is tied low and a missing frame sync is tolerated.
module raster_coord_gen
    import coord_pkg::*;
#(
    parameter int HEIGHT = -1,
    parameter int WIDTH  = -1,
    localparam int V_BITW = log2_width(HEIGHT),
    localparam int H_BITW = log2_width(WIDTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_fsync,
    output logic              out_valid,
    output logic [V_BITW-1:0] out_vcnt,
    output logic [H_BITW-1:0] out_hcnt,
    output logic              out_line_end,
    output logic              out_frame_end,
    output logic              out_sync_err
);

`ifdef RASTER_COORD_SYNC_CHECK_EN
    localparam bit SYNC_CHECK = 1'b1;
`else
    localparam bit SYNC_CHECK = 1'b0;
`endif

    localparam logic [V_BITW-1:0] V_LAST = V_BITW'(HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_LAST = H_BITW'(WIDTH - 1);

    state_t            state;
    logic              start;
    logic              adv;
    logic              late;
    logic              emit;
    logic              h_wrap;
    logic              v_wrap;
    logic              at_origin;
    logic [V_BITW-1:0] next_v;
    logic [H_BITW-1:0] next_h;
`ifdef RASTER_COORD_SYNC_CHECK_EN
    logic              early;
`endif

    // The counters hold the position of the last emitted pixel and drive the
    // coordinate outputs directly, so they are already registered and hold
    // across in_valid gaps.
    mod_counter #(.MODULUS(WIDTH), .BITW(H_BITW)) u_hcnt (
        .clock (clock),
        .reset (reset),
        .clr   (start),
        .inc   (adv),
        .count (out_hcnt),
        .wrap  (h_wrap)
    );

    mod_counter #(.MODULUS(HEIGHT), .BITW(V_BITW)) u_vcnt (
        .clock (clock),
        .reset (reset),
        .clr   (start),
        .inc   (h_wrap),
        .count (out_vcnt),
        .wrap  (v_wrap)
    );

    // Last emitted pixel closed a frame, so the next expected position is (0,0).
    assign at_origin = (out_hcnt == H_LAST) && (out_vcnt == V_LAST);
    assign emit      = start | adv;

    // Classify the incoming pixel: frame start, ordinary advance, or late-sync drop.
    always_comb begin
        // NOTE: every signal gets a default before the branches; a path that
        // leaves one unassigned would infer a latch.
        start = 1'b0;
        adv   = 1'b0;
        late  = 1'b0;
`ifdef RASTER_COORD_SYNC_CHECK_EN
        early = 1'b0;
`endif
        if (in_valid) begin
            if (state == ST_IDLE) begin
                start = in_fsync;
            end else if (in_fsync) begin
                start = 1'b1;
`ifdef RASTER_COORD_SYNC_CHECK_EN
                early = !at_origin;
`endif
            end else if (at_origin && SYNC_CHECK) begin
                late = 1'b1;
            end else begin
                adv = 1'b1;
            end
        end
    end

    // Coordinates the counters will hold after this edge, for the end markers.
    always_comb begin
        next_h = out_hcnt;
        next_v = out_vcnt;
        if (start) begin
            next_h = '0;
            next_v = '0;
        end else if (adv) begin
            next_h = (out_hcnt == H_LAST) ? '0 : out_hcnt + 1'b1;
            if (out_hcnt == H_LAST) begin
                next_v = v_wrap ? '0 : out_vcnt + 1'b1;
            end
        end
    end

    // FSM and registered valid/end-marker outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            out_valid     <= 1'b0;
            out_line_end  <= 1'b0;
            out_frame_end <= 1'b0;
        end else begin
            out_valid     <= emit;
            out_line_end  <= emit && (next_h == H_LAST);
            out_frame_end <= emit && (next_h == H_LAST) && (next_v == V_LAST);
            if (start) begin
                state <= ST_RUN;
            end else if (late) begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef RASTER_COORD_SYNC_CHECK_EN
    // Sticky sync-error flag: set on early or late frame sync, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_sync_err <= 1'b0;
        end else if (early || late) begin
            out_sync_err <= 1'b1;
        end
    end
`else
    assign out_sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_raster_coord_gen.sv
// Scoreboard bench for raster_coord_gen with HEIGHT=3, WIDTH=4. Stimulus pushes
// expected coordinates; a negedge monitor pops and compares each output beat.
module tb_raster_coord_gen;

    localparam int HEIGHT = 3;
    localparam int WIDTH  = 4;

`ifdef RASTER_COORD_SYNC_CHECK_EN
    localparam bit MACRO_ON = 1'b1;
`else
    localparam bit MACRO_ON = 1'b0;
`endif

    typedef struct {
        int v;
        int h;
        bit le;
        bit fe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_fsync = 1'b0;
    logic       out_valid;
    logic [1:0] out_vcnt;
    logic [1:0] out_hcnt;
    logic       out_line_end;
    logic       out_frame_end;
    logic       out_sync_err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_v   = 0;
    int   last_h   = 0;

    raster_coord_gen #(.HEIGHT(HEIGHT), .WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_fsync      (in_fsync),
        .out_valid     (out_valid),
        .out_vcnt      (out_vcnt),
        .out_hcnt      (out_hcnt),
        .out_line_end  (out_line_end),
        .out_frame_end (out_frame_end),
        .out_sync_err  (out_sync_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare each valid beat with the scoreboard; between beats the
    // coordinates must hold and the end markers must stay low.
    always @(negedge clock) begin
        if (reset) begin
            last_v = 0;
            last_h = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("vcnt", int'(out_vcnt), e.v);
                check("hcnt", int'(out_hcnt), e.h);
                check("line_end", int'(out_line_end), int'(e.le));
                check("frame_end", int'(out_frame_end), int'(e.fe));
                last_v = e.v;
                last_h = e.h;
            end
        end else begin
            check("hold_vcnt", int'(out_vcnt), last_v);
            check("hold_hcnt", int'(out_hcnt), last_h);
            check("idle_ends", int'({out_line_end, out_frame_end}), 0);
        end
    end

    // Drive one valid pixel; push its expected coordinates when it should be emitted.
    task automatic pix(input logic f, input bit exp_out, input int v, input int h);
        exp_t e;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_fsync = f;
        if (exp_out) begin
            e.v  = v;
            e.h  = h;
            e.le = (h == 3);
            e.fe = (v == 2) && (h == 3);
            sb.push_back(e);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            in_fsync = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        gap(3);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_vcnt"}, int'(out_vcnt), 0);
        check({tag, "_hcnt"}, int'(out_hcnt), 0);
        check({tag, "_ends"}, int'({out_line_end, out_frame_end}), 0);
        check({tag, "_err"}, int'(out_sync_err), 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // One full frame, fsync on the first pixel, expected (0,0)..(2,3).
        pix(1'b1, 1'b1, 0, 0);
        pix(1'b0, 1'b1, 0, 1);
        pix(1'b0, 1'b1, 0, 2);
        pix(1'b0, 1'b1, 0, 3);
        pix(1'b0, 1'b1, 1, 0);
        pix(1'b0, 1'b1, 1, 1);
        pix(1'b0, 1'b1, 1, 2);
        pix(1'b0, 1'b1, 1, 3);
        pix(1'b0, 1'b1, 2, 0);
        pix(1'b0, 1'b1, 2, 1);
        pix(1'b0, 1'b1, 2, 2);
        pix(1'b0, 1'b1, 2, 3);
        // 13th pixel without fsync: dropped with error (strict), else (0,0).
        pix(1'b0, !MACRO_ON, 0, 0);
        // Strict mode is back in IDLE and ignores this one; otherwise (0,1).
        pix(1'b0, !MACRO_ON, 0, 1);
        drain("frame_drain");
        check("late_sync_err", int'(out_sync_err), int'(MACRO_ON));

        pulse_reset("rst1");

        // Non-fsync pixels after reset are ignored; first fsync pixel starts at (0,0).
        pix(1'b0, 1'b0, 0, 0);
        pix(1'b0, 1'b0, 0, 0);
        pix(1'b0, 1'b0, 0, 0);
        gap(1);
        pix(1'b1, 1'b1, 0, 0);
        // Gaps inside the frame must not skip or repeat coordinates.
        gap($urandom_range(0, 3));
        pix(1'b0, 1'b1, 0, 1);
        gap($urandom_range(0, 3));
        pix(1'b0, 1'b1, 0, 2);
        gap($urandom_range(1, 3));
        pix(1'b0, 1'b1, 0, 3);
        pix(1'b0, 1'b1, 1, 0);
        gap($urandom_range(1, 3));
        pix(1'b0, 1'b1, 1, 1);
        gap(2);
        // Early fsync where (1,2) was expected: restart at (0,0).
        pix(1'b1, 1'b1, 0, 0);
        pix(1'b0, 1'b1, 0, 1);
        gap(1);
        pix(1'b0, 1'b1, 0, 2);
        drain("gap_drain");
        check("early_sync_err", int'(out_sync_err), int'(MACRO_ON));

        pulse_reset("rst2");

        // Reset asserted mid-frame after (1,1) has been emitted.
        pix(1'b1, 1'b1, 0, 0);
        pix(1'b0, 1'b1, 0, 1);
        pix(1'b0, 1'b1, 0, 2);
        pix(1'b0, 1'b1, 0, 3);
        pix(1'b0, 1'b1, 1, 0);
        pix(1'b0, 1'b1, 1, 1);
        drain("mid_drain");
        check("mid_hold_v", int'(out_vcnt), 1);
        check("mid_hold_h", int'(out_hcnt), 1);
        pulse_reset("rst_mid");
        pix(1'b0, 1'b0, 0, 0);
        gap(1);
        pix(1'b1, 1'b1, 0, 0);
        pix(1'b0, 1'b1, 0, 1);
        drain("post_reset_drain");
        check("post_reset_err", int'(out_sync_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
